// File: rtl/prf_scoreboard_pkg.sv
// Shared definitions for the physical register file / scoreboard slice.
// Holds the default geometry of the register file and the index/data types
// used by Rename, Reg. Read and Execute when talking to prf_scoreboard.
package prf_scoreboard_pkg;

    localparam int NUM_PREGS    = 64;
    localparam int XLEN         = 32;
    localparam int NUM_EX_PIPES = 4;
    localparam int IW           = $clog2(NUM_PREGS);

    typedef logic [IW-1:0]   preg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/prf_bypass_mux.sv
// Resolves one read port against all write ports of the current cycle.
// Ports:
//   rd_idx  - PREG index being read
//   wr_vld  - write enables, one per write port
//   wr_idx  - packed write indices
//   wr_val  - packed write data
//   hit     - some valid write port targets rd_idx (index 0 never hits)
//   val     - data of the highest-numbered hitting port (0 when no hit)
module prf_bypass_mux #(
    parameter int XLEN         = prf_scoreboard_pkg::XLEN,
    parameter int IW           = prf_scoreboard_pkg::IW,
    parameter int NUM_WR_PORTS = prf_scoreboard_pkg::NUM_EX_PIPES
) (
    input  logic [IW-1:0]                rd_idx,
    input  logic [NUM_WR_PORTS-1:0]      wr_vld,
    input  logic [NUM_WR_PORTS*IW-1:0]   wr_idx,
    input  logic [NUM_WR_PORTS*XLEN-1:0] wr_val,
    output logic                         hit,
    output logic [XLEN-1:0]              val
);

    // Ascending scan: a later (higher-numbered) port overrides earlier ones.
    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_vld[w] && (wr_idx[w*IW +: IW] == rd_idx) && (rd_idx != '0)) begin
                hit = 1'b1;
                val = wr_val[w*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/prf_scoreboard.sv
// Physical register file with per-PREG ready bits, same-cycle write-to-read
// bypass, rename-time allocation and speculative flush.
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   rd_idx     - packed read indices (NUM_RD_PORTS x IW)
//   rd_val     - packed read data, combinational
//   rd_rdy     - operand ready per read port, combinational
//   wr_vld     - write enables from Execute
//   wr_idx     - packed write indices
//   wr_val     - packed write data
//   alloc_vld  - rename allocation valid per lane
//   alloc_idx  - packed allocated destination PREGs
//   flush      - squash: all ready bits return to 1
//   err_dup_wr - sticky: two valid writes hit the same nonzero index
module prf_scoreboard #(
    parameter int NUM_PREGS    = prf_scoreboard_pkg::NUM_PREGS,
    parameter int XLEN         = prf_scoreboard_pkg::XLEN,
    parameter int NUM_RD_PORTS = 8,
    parameter int NUM_WR_PORTS = prf_scoreboard_pkg::NUM_EX_PIPES,
    parameter int NUM_ALLOC    = 2,
    parameter int IW           = $clog2(NUM_PREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD_PORTS*IW-1:0]   rd_idx,
    output logic [NUM_RD_PORTS*XLEN-1:0] rd_val,
    output logic [NUM_RD_PORTS-1:0]      rd_rdy,
    input  logic [NUM_WR_PORTS-1:0]      wr_vld,
    input  logic [NUM_WR_PORTS*IW-1:0]   wr_idx,
    input  logic [NUM_WR_PORTS*XLEN-1:0] wr_val,
    input  logic [NUM_ALLOC-1:0]         alloc_vld,
    input  logic [NUM_ALLOC*IW-1:0]      alloc_idx,
    input  logic                         flush,
    output logic                         err_dup_wr
);

    logic [XLEN-1:0]      data [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready;
    logic [NUM_PREGS-1:0] ready_nxt;
    logic                 dup_wr;

    // Ready update: writes set, allocs then clear (alloc beats write),
    // flush overrides both.
    always_comb begin
        ready_nxt = ready;
        if (flush) begin
            ready_nxt = '1;
        end else begin
            for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_vld[w] && (wr_idx[w*IW +: IW] != '0))
                    ready_nxt[wr_idx[w*IW +: IW]] = 1'b1;
            end
            for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_vld[a] && (alloc_idx[a*IW +: IW] != '0))
                    ready_nxt[alloc_idx[a*IW +: IW]] = 1'b0;
            end
        end
    end

    always_comb begin
        dup_wr = 1'b0;
        for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR_PORTS; j++) begin
                if (wr_vld[i] && wr_vld[j] &&
                    (wr_idx[i*IW +: IW] == wr_idx[j*IW +: IW]) &&
                    (wr_idx[i*IW +: IW] != '0))
                    dup_wr = 1'b1;
            end
        end
    end

    // Later nonblocking writes win, so the highest-numbered port lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++)
                data[i] <= '0;
            ready      <= '1;
            err_dup_wr <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_vld[w] && (wr_idx[w*IW +: IW] != '0))
                    data[wr_idx[w*IW +: IW]] <= wr_val[w*XLEN +: XLEN];
            end
            ready <= ready_nxt;
            if (dup_wr)
                err_dup_wr <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [IW-1:0]   idx;
        logic            byp_hit;
        logic [XLEN-1:0] byp_val;

        assign idx = rd_idx[p*IW +: IW];

        prf_bypass_mux #(
            .XLEN         (XLEN),
            .IW           (IW),
            .NUM_WR_PORTS (NUM_WR_PORTS)
        ) u_byp (
            .rd_idx (idx),
            .wr_vld (wr_vld),
            .wr_idx (wr_idx),
            .wr_val (wr_val),
            .hit    (byp_hit),
            .val    (byp_val)
        );

        always_comb begin
            if (idx == '0) begin
                rd_val[p*XLEN +: XLEN] = '0;
                rd_rdy[p]              = 1'b1;
            end else begin
                rd_val[p*XLEN +: XLEN] = byp_hit ? byp_val : data[idx];
                rd_rdy[p]              = ready[idx] | byp_hit;
            end
        end
    end

endmodule

// File: tb/tb_prf_scoreboard.sv
module tb_prf_scoreboard;
    import prf_scoreboard_pkg::*;

    localparam int NRD = 8;
    localparam int NWR = 4;
    localparam int NAL = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*IW-1:0]   rd_idx;
    logic [NRD*XLEN-1:0] rd_val;
    logic [NRD-1:0]      rd_rdy;
    logic [NWR-1:0]      wr_vld;
    logic [NWR*IW-1:0]   wr_idx;
    logic [NWR*XLEN-1:0] wr_val;
    logic [NAL-1:0]      alloc_vld;
    logic [NAL*IW-1:0]   alloc_idx;
    logic                flush;
    logic                err_dup_wr;

    int checks = 0;
    int errors = 0;

    // Reference state: one word and one ready flag per PREG, plus sticky error.
    xlen_t m_data [NUM_PREGS];
    bit    m_rdy  [NUM_PREGS];
    bit    m_err;

    always #5 clk = ~clk;

    prf_scoreboard #(
        .NUM_PREGS    (NUM_PREGS),
        .XLEN         (XLEN),
        .NUM_RD_PORTS (NRD),
        .NUM_WR_PORTS (NWR),
        .NUM_ALLOC    (NAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (rd_idx),
        .rd_val     (rd_val),
        .rd_rdy     (rd_rdy),
        .wr_vld     (wr_vld),
        .wr_idx     (wr_idx),
        .wr_val     (wr_val),
        .alloc_vld  (alloc_vld),
        .alloc_idx  (alloc_idx),
        .flush      (flush),
        .err_dup_wr (err_dup_wr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_vld    = '0;
        wr_idx    = '0;
        wr_val    = '0;
        alloc_vld = '0;
        alloc_idx = '0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic set_rd(input int p, input int idx);
        rd_idx[p*IW +: IW] = idx[IW-1:0];
    endtask

    task automatic set_wr(input int w, input int idx, input logic [31:0] v);
        wr_vld[w]              = 1'b1;
        wr_idx[w*IW +: IW]     = idx[IW-1:0];
        wr_val[w*XLEN +: XLEN] = v;
    endtask

    task automatic set_alloc(input int a, input int idx);
        alloc_vld[a]          = 1'b1;
        alloc_idx[a*IW +: IW] = idx[IW-1:0];
    endtask

    // Value/ready a read of index r must see, given the current write inputs.
    task automatic exp_read(input int r, output xlen_t v, output bit y);
        v = m_data[r];
        y = m_rdy[r];
        for (int w = 0; w < NWR; w++)
            if (wr_vld[w] && int'(wr_idx[w*IW +: IW]) == r) begin
                v = wr_val[w*XLEN +: XLEN];
                y = 1'b1;
            end
        if (r == 0) begin
            v = '0;
            y = 1'b1;
        end
    endtask

    task automatic check_all();
        xlen_t v;
        bit    y;
        for (int p = 0; p < NRD; p++) begin
            exp_read(int'(rd_idx[p*IW +: IW]), v, y);
            chk($sformatf("rd_val[%0d]", p), rd_val[p*XLEN +: XLEN], v);
            chk($sformatf("rd_rdy[%0d]", p), {31'b0, rd_rdy[p]}, {31'b0, y});
        end
        chk("err_dup_wr", {31'b0, err_dup_wr}, {31'b0, m_err});
    endtask

    // Advance one clock and apply the same inputs to the reference state.
    task automatic tick();
        int cnt [NUM_PREGS];
        @(posedge clk);
        if (rst) begin
            foreach (m_data[i]) begin
                m_data[i] = '0;
                m_rdy[i]  = 1'b1;
            end
            m_err = 1'b0;
        end else begin
            foreach (cnt[i]) cnt[i] = 0;
            for (int w = 0; w < NWR; w++)
                if (wr_vld[w] && wr_idx[w*IW +: IW] != 0) begin
                    cnt[wr_idx[w*IW +: IW]]++;
                    m_data[wr_idx[w*IW +: IW]] = wr_val[w*XLEN +: XLEN];
                end
            foreach (cnt[i]) if (cnt[i] > 1) m_err = 1'b1;
            if (flush) begin
                foreach (m_rdy[i]) m_rdy[i] = 1'b1;
            end else begin
                for (int w = 0; w < NWR; w++)
                    if (wr_vld[w] && wr_idx[w*IW +: IW] != 0)
                        m_rdy[wr_idx[w*IW +: IW]] = 1'b1;
                for (int a = 0; a < NAL; a++)
                    if (alloc_vld[a] && alloc_idx[a*IW +: IW] != 0)
                        m_rdy[alloc_idx[a*IW +: IW]] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    initial begin
        rd_idx = '0;
        idle();
        foreach (m_data[i]) begin
            m_data[i] = 32'hBAD0_0000 | i;   // reset must overwrite these
            m_rdy[i]  = 1'b0;
        end
        m_err = 1'b0;

        // 1: reset, then read 0 / 5 / 63
        rst = 1'b1;
        tick();
        idle();
        for (int p = 0; p < NRD; p++) set_rd(p, (p % 3 == 0) ? 0 : ((p % 3 == 1) ? 5 : 63));
        settle_check();
        chk("rst_val63", rd_val[2*XLEN +: XLEN], 32'h0);
        chk("rst_rdy5", {31'b0, rd_rdy[1]}, 32'h1);
        chk("rst_err", {31'b0, err_dup_wr}, 32'h0);

        // 2: alloc 7, write DEADBEEF three cycles later
        for (int p = 0; p < NRD; p++) set_rd(p, 7);
        set_alloc(0, 7);
        settle_check();
        chk("alloc_c0_rdy", {31'b0, rd_rdy[0]}, 32'h1);
        tick();
        idle();
        settle_check();
        chk("alloc_c1_rdy", {31'b0, rd_rdy[0]}, 32'h0);
        tick();
        settle_check();
        tick();
        set_wr(0, 7, 32'hDEADBEEF);
        settle_check();
        chk("byp_val7", rd_val[XLEN +: XLEN], 32'hDEADBEEF);
        chk("byp_rdy7", {31'b0, rd_rdy[1]}, 32'h1);
        tick();
        idle();
        settle_check();
        chk("stored_val7", rd_val[0 +: XLEN], 32'hDEADBEEF);
        chk("stored_rdy7", {31'b0, rd_rdy[0]}, 32'h1);

        // 3: duplicate write to idx 9
        set_rd(0, 9);
        set_wr(0, 9, 32'h11);
        set_wr(3, 9, 32'h33);
        settle_check();
        chk("dup_byp9", rd_val[0 +: XLEN], 32'h33);
        tick();
        idle();
        settle_check();
        chk("dup_store9", rd_val[0 +: XLEN], 32'h33);
        chk("dup_err", {31'b0, err_dup_wr}, 32'h1);
        tick();
        settle_check();
        chk("dup_err_sticky", {31'b0, err_dup_wr}, 32'h1);

        // 4: alloc and write idx 12 together
        set_rd(1, 12);
        set_alloc(1, 12);
        set_wr(2, 12, 32'h5);
        settle_check();
        tick();
        idle();
        settle_check();
        chk("aw_val12", rd_val[XLEN +: XLEN], 32'h5);
        chk("aw_rdy12", {31'b0, rd_rdy[1]}, 32'h0);

        // 5: alloc 20/21, then flush with alloc 22 and write 21
        set_rd(0, 20); set_rd(1, 21); set_rd(2, 22);
        set_alloc(0, 20); set_alloc(1, 21);
        settle_check();
        tick();
        idle();
        settle_check();
        set_alloc(0, 22);
        set_wr(1, 21, 32'hA);
        flush = 1'b1;
        settle_check();
        tick();
        idle();
        settle_check();
        chk("fl_rdy20", {31'b0, rd_rdy[0]}, 32'h1);
        chk("fl_rdy21", {31'b0, rd_rdy[1]}, 32'h1);
        chk("fl_rdy22", {31'b0, rd_rdy[2]}, 32'h1);
        chk("fl_val21", rd_val[XLEN +: XLEN], 32'hA);

        // 6: PREG 0 is hardwired; fresh reset so err starts at 0
        rst = 1'b1;
        tick();
        idle();
        for (int p = 0; p < NRD; p++) set_rd(p, 0);
        set_wr(0, 0, 32'hFFFFFFFF);
        set_wr(1, 0, 32'hFFFFFFFF);
        set_alloc(0, 0);
        settle_check();
        chk("p0_byp_val", rd_val[0 +: XLEN], 32'h0);
        tick();
        idle();
        settle_check();
        chk("p0_val", rd_val[0 +: XLEN], 32'h0);
        chk("p0_rdy", {31'b0, rd_rdy[0]}, 32'h1);
        chk("p0_no_err", {31'b0, err_dup_wr}, 32'h0);

        // Random traffic on a narrow index range to force collisions
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 15));
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) == 0) set_wr(w, $urandom_range(0, 15), $urandom);
            for (int a = 0; a < NAL; a++)
                if ($urandom_range(0, 2) == 0) set_alloc(a, $urandom_range(0, 15));
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            settle_check();
            tick();
        end
        idle();
        settle_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
